// File: rtl/ram0_ctrl_pkg.sv
// Shared definitions for the RAM0 access controller: state encoding,
// default access lengths and a small counter-load helper.
package ram0_ctrl_pkg;

  // Default access lengths in CLK cycles (read legal 2..15, write legal 3..15)
  localparam int RD_CYCLES_DEF = 4;
  localparam int WR_CYCLES_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SRD  = 3'd1,
    ST_SWR  = 3'd2,
    ST_MRD  = 3'd3,
    ST_MWR  = 3'd4
  } state_t;

  // The access timer counts down to zero, so it starts at length-1
  function automatic logic [3:0] cyc_load(input int n);
    return 4'(n - 1);
  endfunction

endpackage

// File: rtl/ram0_ctrl_if.sv
// SNES, MCU and RAM-side signals of the RAM0 controller.
// master = system side (SNES bus logic, MCU, RAM device), slave = controller.
interface ram0_ctrl_if;
  logic        SNES_RD_start;
  logic        SNES_WR_end;
  logic        ram0_enable;
  logic [23:0] ram0_addr;
  logic [7:0]  SNES_DATA_IN;
  logic [7:0]  SNES_DATA_OUT;

  logic        MCU_RRQ;
  logic        MCU_WRQ;
  logic [23:0] MCU_ADDR;
  logic [7:0]  MCU_DOUT;
  logic [7:0]  MCU_DINr;
  logic        MCU_RDY;

  logic [23:0] RAM_ADDR;
  logic [7:0]  RAM_DATA_O;
  logic [7:0]  RAM_DATA_I;
  logic        RAM_OE_N;
  logic        RAM_WE_N;
  logic        RAM_DRIVE;

  modport master (
    output SNES_RD_start, SNES_WR_end, ram0_enable, ram0_addr, SNES_DATA_IN,
    output MCU_RRQ, MCU_WRQ, MCU_ADDR, MCU_DOUT, RAM_DATA_I,
    input  SNES_DATA_OUT, MCU_DINr, MCU_RDY,
    input  RAM_ADDR, RAM_DATA_O, RAM_OE_N, RAM_WE_N, RAM_DRIVE
  );

  modport slave (
    input  SNES_RD_start, SNES_WR_end, ram0_enable, ram0_addr, SNES_DATA_IN,
    input  MCU_RRQ, MCU_WRQ, MCU_ADDR, MCU_DOUT, RAM_DATA_I,
    output SNES_DATA_OUT, MCU_DINr, MCU_RDY,
    output RAM_ADDR, RAM_DATA_O, RAM_OE_N, RAM_WE_N, RAM_DRIVE
  );
endinterface

// File: rtl/ram0_ctrl_req_latch.sv
// Holds one pending access request (address, write data, direction).
// A new request in the same cycle as a clear wins, so a strobe arriving
// exactly when the previous one is taken is not lost.
module ram0_req_latch (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        set,
  input  logic        clr,
  input  logic [23:0] addr_in,
  input  logic [7:0]  data_in,
  input  logic        wr_in,
  output logic        pend,
  output logic [23:0] addr,
  output logic [7:0]  data,
  output logic        wr
);

  // Capture a request on set, drop the pending flag on clr
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pend <= 1'b0;
      addr <= '0;
      data <= '0;
      wr   <= 1'b0;
    end else if (set) begin
      pend <= 1'b1;
      addr <= addr_in;
      data <= data_in;
      wr   <= wr_in;
    end else if (clr) begin
      pend <= 1'b0;
    end
  end

endmodule

// File: rtl/ram0_ctrl.sv
// RAM0 access controller: arbitrates SNES and MCU requests onto a single
// asynchronous SRAM port with fixed-length read and write cycles.
//
//   state | meaning
//   IDLE  | no access; strobes inactive, last address held
//   SRD   | SNES read, OE_N low, data captured on last cycle
//   SWR   | SNES write, bus driven, WE_N low except first/last cycle
//   MRD   | MCU read, OE_N low, data captured on last cycle
//   MWR   | MCU write, bus driven, WE_N low except first/last cycle
module ram0_ctrl
  import ram0_ctrl_pkg::*;
#(
  parameter int RD_CYCLES = RD_CYCLES_DEF,
  parameter int WR_CYCLES = WR_CYCLES_DEF
) (
  input logic        CLK,
  input logic        RST_N,
  ram0_ctrl_if.slave bus
);

  localparam logic [3:0] RD_LOAD = cyc_load(RD_CYCLES);
  localparam logic [3:0] WR_LOAD = cyc_load(WR_CYCLES);

  state_t      state, state_nxt;
  logic [3:0]  cnt;

  logic        snes_set, snes_wr_in, snes_pend, snes_wr;
  logic [23:0] snes_addr;
  logic [7:0]  snes_data;
  logic        mcu_set, mcu_wr_in, mcu_pend, mcu_wr;
  logic [23:0] mcu_addr;
  logic [7:0]  mcu_data;

  logic        start_snes, start_mcu, acc_done, mcu_done;
  logic        oe_n, we_n, drive;
  logic [23:0] ram_addr_q;
  logic [7:0]  ram_data_q, snes_dout_q, mcu_din_q;

  // SNES strobes count only on a RAM0 hit; read wins over a same-cycle write.
  // MCU strobes are ignored while an MCU request is still outstanding.
  assign snes_set   = (bus.SNES_RD_start | bus.SNES_WR_end) & bus.ram0_enable;
  assign snes_wr_in = bus.SNES_WR_end & ~bus.SNES_RD_start;
  assign mcu_set    = (bus.MCU_RRQ | bus.MCU_WRQ) & ~mcu_pend;
  assign mcu_wr_in  = bus.MCU_WRQ & ~bus.MCU_RRQ;

  assign start_snes = (state == ST_IDLE) & snes_pend;
  assign start_mcu  = (state == ST_IDLE) & ~snes_pend & mcu_pend;
  assign acc_done   = (state != ST_IDLE) & (cnt == 4'd0);
  assign mcu_done   = acc_done & ((state == ST_MRD) | (state == ST_MWR));

  ram0_req_latch u_snes_req (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .set     (snes_set),
    .clr     (start_snes),
    .addr_in (bus.ram0_addr),
    .data_in (bus.SNES_DATA_IN),
    .wr_in   (snes_wr_in),
    .pend    (snes_pend),
    .addr    (snes_addr),
    .data    (snes_data),
    .wr      (snes_wr)
  );

  // MCU request stays pending for the whole access so MCU_RDY tracks it
  ram0_req_latch u_mcu_req (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .set     (mcu_set),
    .clr     (mcu_done),
    .addr_in (bus.MCU_ADDR),
    .data_in (bus.MCU_DOUT),
    .wr_in   (mcu_wr_in),
    .pend    (mcu_pend),
    .addr    (mcu_addr),
    .data    (mcu_data),
    .wr      (mcu_wr)
  );

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state selection and RAM strobes decoded from state and timer
  always_comb begin
    state_nxt = state;
    oe_n      = 1'b1;
    we_n      = 1'b1;
    drive     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (snes_pend)     state_nxt = snes_wr ? ST_SWR : ST_SRD;
        else if (mcu_pend) state_nxt = mcu_wr ? ST_MWR : ST_MRD;
      end
      ST_SRD, ST_MRD: begin
        oe_n = 1'b0;
        if (cnt == 4'd0) state_nxt = ST_IDLE;
      end
      ST_SWR, ST_MWR: begin
        drive = 1'b1;
        we_n  = (cnt == WR_LOAD) | (cnt == 4'd0);
        if (cnt == 4'd0) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Access timer, address/data launch on entry, read data capture on exit
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt         <= 4'd0;
      ram_addr_q  <= '0;
      ram_data_q  <= '0;
      snes_dout_q <= '0;
      mcu_din_q   <= '0;
    end else if (start_snes) begin
      cnt        <= snes_wr ? WR_LOAD : RD_LOAD;
      ram_addr_q <= snes_addr;
      ram_data_q <= snes_data;
    end else if (start_mcu) begin
      cnt        <= mcu_wr ? WR_LOAD : RD_LOAD;
      ram_addr_q <= mcu_addr;
      ram_data_q <= mcu_data;
    end else if (state != ST_IDLE) begin
      if (cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end else begin
        if (state == ST_SRD) snes_dout_q <= bus.RAM_DATA_I;
        if (state == ST_MRD) mcu_din_q   <= bus.RAM_DATA_I;
      end
    end
  end

  assign bus.RAM_OE_N      = oe_n;
  assign bus.RAM_WE_N      = we_n;
  assign bus.RAM_DRIVE     = drive;
  assign bus.RAM_ADDR      = ram_addr_q;
  assign bus.RAM_DATA_O    = ram_data_q;
  assign bus.SNES_DATA_OUT = snes_dout_q;
  assign bus.MCU_DINr      = mcu_din_q;
  assign bus.MCU_RDY       = ~mcu_pend;

endmodule

// File: tb/tb_ram0_ctrl.sv
// Testbench for ram0_ctrl: directed scenarios followed by random traffic,
// checked every cycle against a transaction-level reference model.
module tb_ram0_ctrl;

  localparam int RDC = 4;
  localparam int WRC = 4;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  int   checks = 0;
  int   errors = 0;

  ram0_ctrl_if bus ();

  ram0_ctrl #(.RD_CYCLES(RDC), .WR_CYCLES(WRC)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  // SRAM device model: initial pattern i^0x91, written while WE_N is low
  logic [7:0] ram [256];
  bit         ram_fill = 1'b1;
  always @(posedge CLK) begin
    if (ram_fill) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'(i) ^ 8'h91;
    end else if (bus.RAM_WE_N === 1'b0) begin
      ram[bus.RAM_ADDR[7:0]] <= bus.RAM_DATA_O;
    end
  end
  assign bus.RAM_DATA_I = ram[bus.RAM_ADDR[7:0]];

  // Reference model: current operation (0 none, 1 snes rd, 2 snes wr,
  // 3 mcu rd, 4 mcu wr), cycles elapsed in it, and the pending requests
  int          m_op, m_age;
  bit          sp, sp_wr, mp, mp_wr;
  logic [23:0] sp_addr, mp_addr, e_addr;
  logic [7:0]  sp_data, mp_data, e_wdata, e_sout, e_mdin;
  logic [7:0]  mmem [256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_op = 0; m_age = 0;
    sp = 0; sp_wr = 0; mp = 0; mp_wr = 0;
    sp_addr = '0; mp_addr = '0; e_addr = '0;
    sp_data = '0; mp_data = '0; e_wdata = '0; e_sout = '0; e_mdin = '0;
  endtask

  task automatic model_step();
    bit old_mp;
    int len;
    if (!RST_N) begin
      model_reset();
      return;
    end
    old_mp = mp;
    if (m_op == 0) begin
      if (sp) begin
        m_op = sp_wr ? 2 : 1; m_age = 0;
        e_addr = sp_addr; e_wdata = sp_data; sp = 0;
      end else if (mp) begin
        m_op = mp_wr ? 4 : 3; m_age = 0;
        e_addr = mp_addr; e_wdata = mp_data;
      end
    end else begin
      len = (m_op == 1 || m_op == 3) ? RDC : WRC;
      if (m_age == len - 1) begin
        if (m_op == 1) e_sout = mmem[e_addr[7:0]];
        if (m_op == 3) e_mdin = mmem[e_addr[7:0]];
        if (m_op == 2 || m_op == 4) mmem[e_addr[7:0]] = e_wdata;
        if (m_op >= 3) mp = 0;
        m_op = 0;
      end else begin
        m_age++;
      end
    end
    if ((bus.SNES_RD_start || bus.SNES_WR_end) && bus.ram0_enable) begin
      sp = 1; sp_addr = bus.ram0_addr; sp_data = bus.SNES_DATA_IN;
      sp_wr = !bus.SNES_RD_start;
    end
    if ((bus.MCU_RRQ || bus.MCU_WRQ) && !old_mp) begin
      mp = 1; mp_addr = bus.MCU_ADDR; mp_data = bus.MCU_DOUT;
      mp_wr = !bus.MCU_RRQ;
    end
  endtask

  task automatic check_outputs();
    bit rd, wr;
    rd = (m_op == 1) || (m_op == 3);
    wr = (m_op == 2) || (m_op == 4);
    chk("oe_n",      32'(bus.RAM_OE_N),      32'(!rd));
    chk("we_n",      32'(bus.RAM_WE_N),      32'(!(wr && m_age != 0 && m_age != WRC - 1)));
    chk("drive",     32'(bus.RAM_DRIVE),     32'(wr));
    chk("ram_addr",  32'(bus.RAM_ADDR),      32'(e_addr));
    if (wr) chk("ram_data_o", 32'(bus.RAM_DATA_O), 32'(e_wdata));
    chk("snes_dout", 32'(bus.SNES_DATA_OUT), 32'(e_sout));
    chk("mcu_din",   32'(bus.MCU_DINr),      32'(e_mdin));
    chk("mcu_rdy",   32'(bus.MCU_RDY),       32'(!mp));
  endtask

  task automatic cycle();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    check_outputs();
  endtask

  task automatic clear_strobes();
    bus.SNES_RD_start = 0; bus.SNES_WR_end = 0;
    bus.MCU_RRQ = 0; bus.MCU_WRQ = 0;
  endtask

  initial begin
    int oe_low, we_low, rdy_k, oe_k;
    logic [23:0] first_oe_addr;
    logic [7:0]  mdin_before;

    clear_strobes();
    bus.ram0_enable = 0; bus.ram0_addr = '0; bus.SNES_DATA_IN = '0;
    bus.MCU_ADDR = '0; bus.MCU_DOUT = '0;
    for (int i = 0; i < 256; i++) mmem[i] = 8'(i) ^ 8'h91;
    model_reset();

    // Reset values
    cycle();
    cycle();
    chk("rst_oe_n",  32'(bus.RAM_OE_N),  32'd1);
    chk("rst_we_n",  32'(bus.RAM_WE_N),  32'd1);
    chk("rst_drive", 32'(bus.RAM_DRIVE), 32'd0);
    chk("rst_rdy",   32'(bus.MCU_RDY),   32'd1);
    chk("rst_addr",  32'(bus.RAM_ADDR),  32'd0);
    RST_N = 1'b1;
    ram_fill = 1'b0;
    cycle();

    // SNES read of 0x001234 returning 0xA5
    bus.ram0_enable = 1; bus.ram0_addr = 24'h001234; bus.SNES_RD_start = 1;
    cycle();
    clear_strobes();
    oe_low = 0;
    for (int k = 1; k <= 8; k++) begin
      cycle();
      if (bus.RAM_OE_N === 1'b0) oe_low++;
      if (k == 4) chk("srd_not_yet", 32'(bus.SNES_DATA_OUT == 8'hA5), 32'd0);
      if (k == 5) chk("srd_data_t5", 32'(bus.SNES_DATA_OUT), 32'hA5);
    end
    chk("srd_oe_cycles", 32'(oe_low), 32'd4);

    // SNES write with ram0_enable=0 is ignored
    bus.ram0_enable = 0; bus.ram0_addr = 24'h000050; bus.SNES_DATA_IN = 8'h77;
    bus.SNES_WR_end = 1;
    cycle();
    clear_strobes();
    we_low = 0;
    for (int k = 0; k < 6; k++) begin
      cycle();
      if (bus.RAM_WE_N !== 1'b1 || bus.RAM_DRIVE !== 1'b0) we_low++;
    end
    chk("wr_disabled_we", 32'(we_low), 32'd0);

    // MCU write, SNES read one cycle later
    bus.MCU_WRQ = 1; bus.MCU_ADDR = 24'h120000; bus.MCU_DOUT = 8'h5A;
    cycle();
    clear_strobes();
    chk("mwr_rdy_low", 32'(bus.MCU_RDY), 32'd0);
    bus.ram0_enable = 1; bus.ram0_addr = 24'h000010; bus.SNES_RD_start = 1;
    cycle();
    clear_strobes();
    we_low = 0; rdy_k = -1; oe_k = -1;
    for (int k = 1; k <= 14; k++) begin
      cycle();
      if (bus.RAM_WE_N === 1'b0) we_low++;
      if (rdy_k < 0 && bus.MCU_RDY === 1'b1) rdy_k = k;
      if (oe_k < 0 && bus.RAM_OE_N === 1'b0) oe_k = k;
    end
    chk("mwr_we_cycles", 32'(we_low), 32'd2);
    chk("mwr_then_srd",  32'(rdy_k > 0 && oe_k > rdy_k), 32'd1);

    // MCU read and SNES read in the same cycle: SNES first
    mdin_before = bus.MCU_DINr;
    bus.MCU_RRQ = 1; bus.MCU_ADDR = 24'h000020;
    bus.ram0_enable = 1; bus.ram0_addr = 24'h000030; bus.SNES_RD_start = 1;
    cycle();
    clear_strobes();
    first_oe_addr = '1;
    for (int k = 1; k <= 14; k++) begin
      cycle();
      if (first_oe_addr === '1 && bus.RAM_OE_N === 1'b0) first_oe_addr = bus.RAM_ADDR;
      if (k == 9)  chk("mrd_din_held", 32'(bus.MCU_DINr), 32'(mdin_before));
      if (k == 10) chk("mrd_din_new",  32'(bus.MCU_DINr), 32'(8'h20 ^ 8'h91));
    end
    chk("srd_first_addr", 32'(first_oe_addr), 32'h000030);

    // Reset during the second cycle of a SNES write
    bus.ram0_enable = 1; bus.ram0_addr = 24'h000040; bus.SNES_DATA_IN = 8'h3C;
    bus.SNES_WR_end = 1;
    cycle();
    clear_strobes();
    cycle();
    cycle();
    chk("swr_mid_we", 32'(bus.RAM_WE_N), 32'd0);
    RST_N = 1'b0;
    #1;
    chk("abort_we_n",  32'(bus.RAM_WE_N),  32'd1);
    chk("abort_drive", 32'(bus.RAM_DRIVE), 32'd0);
    model_reset();
    check_outputs();
    cycle();
    cycle();
    RST_N = 1'b1;
    cycle();
    chk("post_abort_rdy", 32'(bus.MCU_RDY), 32'd1);
    cycle();

    // Random traffic
    for (int n = 0; n < 500; n++) begin
      bus.SNES_RD_start = ($urandom_range(0, 11) == 0);
      bus.SNES_WR_end   = ($urandom_range(0, 11) == 0);
      bus.ram0_enable   = ($urandom_range(0, 3) != 0);
      bus.ram0_addr     = {16'($urandom), 8'($urandom_range(0, 15))};
      bus.SNES_DATA_IN  = 8'($urandom);
      bus.MCU_RRQ       = ($urandom_range(0, 9) == 0);
      bus.MCU_WRQ       = ($urandom_range(0, 9) == 0);
      bus.MCU_ADDR      = {16'($urandom), 8'($urandom_range(0, 15))};
      bus.MCU_DOUT      = 8'($urandom);
      cycle();
      chk("oe_we_exclusive", 32'(bus.RAM_OE_N | bus.RAM_WE_N), 32'd1);
    end
    clear_strobes();
    for (int k = 0; k < 20; k++) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram0_ctrl.md
RAM0_CTRL -- requirements
Module: ram0_ctrl

Interface
REQ-001 SHALL have parameter RD_CYCLES, default 4, RAM read access length in CLK cycles (legal 2..15).
REQ-002 SHALL have parameter WR_CYCLES, default 4, RAM write access length in CLK cycles (legal 3..15).
REQ-003 CLK  in  1  sole clock; all state changes on its rising edge.
REQ-004 RST_N  in  1  reset, asynchronous, active-low.
REQ-005 SNES_RD_start  in  1  one-cycle pulse: SNES read cycle began (already synchronised to CLK).
REQ-006 SNES_WR_end  in  1  one-cycle pulse: SNES write data valid, cycle ending.
REQ-007 ram0_enable  in  1  address decoder says the current SNES address hits RAM0.
REQ-008 ram0_addr  in  24  RAM0 address from the address decoder.
REQ-009 SNES_DATA_IN  in  8  SNES write data; SNES_DATA_OUT  out  8  registered read data to SNES.
REQ-010 MCU_RRQ / MCU_WRQ  in  1 each  one-cycle MCU read/write request pulses.
REQ-011 MCU_ADDR  in  24, MCU_DOUT  in  8  MCU address/write data, sampled with the request.
REQ-012 MCU_DINr  out  8  registered MCU read data; MCU_RDY  out  1  high when no MCU request outstanding.
REQ-013 RAM_ADDR  out  24, RAM_DATA_O  out  8, RAM_DATA_I  in  8, RAM_OE_N  out  1, RAM_WE_N  out  1, RAM_DRIVE  out  1 (high = FPGA drives RAM data bus).

Function
REQ-014 States SHALL be IDLE, SRD, SWR, MRD, MWR; one access at a time.
REQ-015 SNES strobe SHALL be accepted only if ram0_enable=1 in the strobe cycle; ram0_addr (and SNES_DATA_IN for writes) latched that same cycle.
REQ-016 MCU strobe SHALL latch MCU_ADDR/MCU_DOUT, set a pending flag and drop MCU_RDY the next cycle.
REQ-017 From IDLE, priority SHALL be: pending SNES > pending MCU; SNES read/write pulses in the same cycle: read wins, write dropped.
REQ-018 A SNES strobe arriving during an MCU access SHALL be held pending and served immediately after; a second SNES strobe while one is pending SHALL overwrite it.
REQ-019 MCU requests arriving while one is pending SHALL be ignored (MCU must wait for MCU_RDY=1).
REQ-020 Access state SHALL last exactly RD_CYCLES/WR_CYCLES cycles via 4-bit down-counter loaded with N-1; exit to IDLE when counter=0.
REQ-021 Read state: RAM_OE_N=0 for all cycles, RAM_DRIVE=0; RAM_DATA_I captured on the final cycle into SNES_DATA_OUT (SRD) or MCU_DINr (MRD).
REQ-022 Write state: RAM_DRIVE=1 for all cycles; RAM_WE_N=0 on all cycles except first and last (address/data setup and hold).
REQ-023 Latency from idle: SNES_RD_start at edge t -> SRD entered t+1 -> SNES_DATA_OUT valid from t+RD_CYCLES+1.
REQ-024 MCU_RDY SHALL rise the cycle after the MCU access completes; the pending flag clears there.
REQ-025 RAM_ADDR SHALL hold the latched address of the active access and keep its last value in IDLE.
REQ-026 OE_N and WE_N SHALL never be 0 simultaneously; IDLE drives OE_N=1, WE_N=1, DRIVE=0.

Reset
REQ-027 While RST_N=0: state IDLE, counter 0, pending flags 0, MCU_RDY=1, RAM_OE_N=1, RAM_WE_N=1, RAM_DRIVE=0, all data/address outputs 0.
REQ-028 Reset mid-access SHALL abort immediately (asynchronously deassert WE_N/DRIVE); the aborted request is lost.

Structure
REQ-029 State encoding and default cycle constants SHALL live in the shared sd2snes package; no sub-module needed beyond an optional request-latch helper named ram0_req_latch.

Verification
REQ-030 SNES read idle, ram0_enable=1, addr 0x00_1234, RAM returns 0xA5 -> OE_N low 4 cycles, SNES_DATA_OUT=0xA5 at t+5.
REQ-031 SNES_WR_end with ram0_enable=0 -> no state change, RAM_WE_N stays 1.
REQ-032 MCU write 0x5A@0x12_0000, SNES read strobe 1 cycle later -> MWR completes (WE_N low 2 cycles), then SRD, MCU_RDY rises after MWR.
REQ-033 MCU read and SNES read same cycle -> SRD first, then MRD; MCU_DINr updated only after MRD.
REQ-034 RST_N low in 2nd cycle of SWR -> WE_N=1, DRIVE=0 immediately; after release IDLE, MCU_RDY=1.
